instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the immediate sign-extender in the 64-bit RISC-V core.
- Holds the PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Latches the returned word into the instruction register (ir_out), which drives the extender, decode and control inputs.
- Holds ir_out while the pipeline stalls; accepts PC redirects from branch/JAL/JALR resolution.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_W, 64, PC and address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-low (reset=0 resets on the next clk edge).
- imem_req  out  1  fetch request; high only in state S_REQ.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_ack  in  1  memory response strobe, one cycle; ignored outside S_WAIT.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- stall  in  1  downstream not ready; the held instruction is not consumed.
- redirect_valid  in  1  load new PC (branch taken, JAL or JALR).
- redirect_target  in  PC_W  new PC value.
- ir_valid  out  1  ir_out holds a valid instruction.
- ir_out  out  32  instruction register; feeds the sign-extender.
- ir_pc  out  PC_W  PC of the instruction in ir_out.
- fetch_misaligned  out  1  redirect target not 4-byte aligned; fetch halted.

Behaviour:
- Reset (reset=0 at an edge): pc=RESET_PC, state=S_REQ, ir_valid=0, ir_out=32'h0, ir_pc=0, drop=0, fetch_misaligned=0. Reset mid-transaction abandons the transaction; a late imem_ack is ignored because state is S_REQ.
- States:
  - S_REQ: imem_req=1, imem_addr=pc. Next state S_WAIT, always after exactly one cycle.
  - S_WAIT: imem_req=0. Waits any number of cycles for imem_ack.
    - On ack with drop=0: ir_out<=imem_rdata, ir_pc<=pc, ir_valid<=1, pc<=pc+4, go to S_HOLD.
    - On ack with drop=1: discard the data, drop<=0, go to S_REQ.
  - S_HOLD: ir_valid=1 and ir_out stable while stall=1. When stall=0: ir_valid<=0, go to S_REQ.
  - S_ERR: imem_req=0, ir_valid=0, fetch_misaligned=1. Left only by reset or by an aligned redirect, which goes to S_REQ.
- Fetch latency: minimum 3 cycles from S_REQ entry to ir_valid=1 (ack on the first S_WAIT cycle). Sustained throughput with no stalls is one instruction per 3 cycles.
- Redirect (redirect_valid=1, highest priority over ack and stall). Always pc<=redirect_target and ir_valid<=0. Then, by state:
  - S_REQ: the in-flight request must still be acknowledged, so drop<=1 and go to S_WAIT.
  - S_WAIT without ack: drop<=1, stay in S_WAIT.
  - S_WAIT with ack in the same cycle: discard the data, drop<=0, go to S_REQ.
  - S_HOLD: go to S_REQ; stall is ignored.
- Misaligned target (redirect_target[1:0]!=0): pc is still loaded; fetch_misaligned<=1.
  - If a request is outstanding, first drain it (S_WAIT with drop=1), then enter S_ERR instead of S_REQ.
  - Otherwise enter S_ERR directly.
- pc+4 wraps modulo 2^PC_W; no overflow flag.
- ir_out, ir_pc and ir_valid are registered outputs. imem_req and imem_addr are decoded from state and pc only, with no combinational path from inputs.

Test Plan:
- Reset then release, ack one cycle after req with rdata=32'h00500093 -> imem_addr=0x0; ir_valid=1 on cycle 3 with ir_out=32'h00500093, ir_pc=0; next request addr=0x4.
- stall=1 for 5 cycles while in S_HOLD -> ir_out and ir_pc unchanged, imem_req=0 throughout; release -> ir_valid=0 next cycle, then req addr=0x8.
- Redirect to 0x100 during S_WAIT, ack 2 cycles later with 32'hDEADBEEF -> data discarded (ir_valid stays 0); next req addr=0x100.
- Redirect to 0x200 in the same cycle as ack -> no ir_valid; next cycle req addr=0x200.
- Redirect to 0x102 -> fetch_misaligned=1, imem_req stays 0; aligned redirect to 0x40 -> flag clears, req addr=0x40.
- Reset=0 asserted while in S_WAIT, then ack arrives -> pc=RESET_PC, ack ignored, fresh req at RESET_PC; pc=0xFFFFFFFFFFFFFFFC fetch -> next addr=0x0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_unit_if #(
    parameter int unsigned PC_W = 64
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues single-outstanding imem requests and
// latches the returned word into the instruction register.
module instr_fetch_unit #(
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_unit_if.master   imem,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_target,
    output logic                 ir_valid,
    output logic [31:0]          ir_out,
    output logic [PC_W-1:0]      ir_pc,
    output logic                 fetch_misaligned
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;

    state_t          state;
    state_t          state_nx;
    logic [PC_W-1:0] pc;
    logic            drop;
    logic            tgt_mis;
    logic            busy_after;

    assign tgt_mis    = |redirect_target[1:0];
    // A request issued this cycle, or still unanswered, must be drained.
    assign busy_after = (state == S_REQ) || ((state == S_WAIT) && !imem.imem_ack);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (redirect_valid) begin
            if (busy_after) begin
                state_nx = S_WAIT;
            end else begin
                state_nx = tgt_mis ? S_ERR : S_REQ;
            end
        end else begin
            case (state)
                S_REQ:  state_nx = S_WAIT;
                S_WAIT: begin
                    if (imem.imem_ack) begin
                        // A drained redirect lands in S_ERR if its target was misaligned.
                        if (drop) begin
                            state_nx = fetch_misaligned ? S_ERR : S_REQ;
                        end else begin
                            state_nx = S_HOLD;
                        end
                    end
                end
                S_HOLD: if (!stall) state_nx = S_REQ;
                S_ERR:  state_nx = S_ERR;
                default: state_nx = S_REQ;
            endcase
        end
    end

    always_comb begin
        imem.imem_req  = (state == S_REQ);
        imem.imem_addr = pc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc               <= RESET_PC;
            drop             <= 1'b0;
            ir_valid         <= 1'b0;
            ir_out           <= '0;
            ir_pc            <= '0;
            fetch_misaligned <= 1'b0;
        end else if (redirect_valid) begin
            pc               <= redirect_target;
            ir_valid         <= 1'b0;
            fetch_misaligned <= tgt_mis;
            drop             <= busy_after;
        end else if ((state == S_WAIT) && imem.imem_ack) begin
            if (drop) begin
                drop <= 1'b0;
            end else begin
                ir_out   <= imem.imem_rdata;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
                pc       <= pc + PC_W'(4);
            end
        end else if ((state == S_HOLD) && !stall) begin
            ir_valid <= 1'b0;
        end
    end

endmodule
